// File: rtl/ula_pkg.sv
// Shared types for the serial ALU: FSM states, function select, mode.
// Imported by ula_fatia4 and ula_serial_nbit.
package ula_pkg;

    typedef enum logic [1:0] {OCIOSO, CALC, PRONTO} estado_t;

    typedef logic [3:0] sel_t;

    localparam logic MODO_ARIT = 1'b0;
    localparam logic MODO_LOG  = 1'b1;

endpackage

// File: rtl/ula_fatia4.sv
// Combinational 4-bit 74181-style slice, time-multiplexed by the top.
// Ports: A, B slices; s select; m mode; cy_in carry in; F result;
//   cy_out carry out (0 in logic mode); cy_msb carry into bit 3 (ULA_OVF_EN).
module ula_fatia4
    import ula_pkg::*;
(
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  sel_t       s,
    input  logic       m,
    input  logic       cy_in,
    output logic [3:0] F,
    output logic       cy_out
`ifdef ULA_OVF_EN
    ,
    output logic       cy_msb
`endif
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] soma;

    assign p = A | (B & {4{s[0]}}) | (~B & {4{s[1]}});
    assign g = (A & B & {4{s[3]}}) | (A & ~B & {4{s[2]}});

    assign soma = {1'b0, p} + {1'b0, g} + {4'b0, cy_in};

    assign F      = (m == MODO_LOG) ? ~(p ^ g) : soma[3:0];
    assign cy_out = (m == MODO_ARIT) & soma[4];

`ifdef ULA_OVF_EN
    // Sum of the low three bits only; its MSB is the carry into bit 3.
    logic [3:0] baixo;
    assign baixo  = {1'b0, p[2:0]} + {1'b0, g[2:0]} + {3'b0, cy_in};
    assign cy_msb = (m == MODO_ARIT) & baixo[3];
`endif

endmodule

// File: rtl/ula_serial_nbit.sv
// Serial WIDTH-bit 74181-style ALU, one 4-bit slice per clock, LSB first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, s, m, c_in;
//   out_valid/out_ready + f, c_out, a_eq_b, zero; ovf when ULA_OVF_EN is defined.
module ula_serial_nbit
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             a_eq_b,
    output logic             zero
`ifdef ULA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_FATIAS = WIDTH / 4;
    localparam int CW = (NUM_FATIAS > 1) ? $clog2(NUM_FATIAS) : 1;
    localparam logic [CW-1:0] ULTIMA = CW'(NUM_FATIAS - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_largura_invalida
        $error("ula_serial_nbit: WIDTH must be a multiple of 4 and >= 4");
    end

    estado_t          estado_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    sel_t             s_q;
    logic             m_q, cy_q;
    logic [CW-1:0]    cnt_q;
    logic             c_out_q, aeqb_q, zero_q;
    logic             in_ready_q, out_valid_q;

    logic [3:0] a_sl, b_sl, f_sl;
    logic       cy_sl;

    // Route the slice selected by the counter into the shared datapath.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NUM_FATIAS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[4*i +: 4];
                b_sl = b_q[4*i +: 4];
            end
        end
    end

    // Result with the current slice merged in; zero flag is taken from this.
    always_comb begin
        res_d = res_q;
        for (int i = 0; i < NUM_FATIAS; i++) begin
            if (cnt_q == CW'(i)) begin
                res_d[4*i +: 4] = f_sl;
            end
        end
    end

`ifdef ULA_OVF_EN
    logic cy_msb_sl;
    logic ovf_q;
`endif

    ula_fatia4 u_fatia (
        .A      (a_sl),
        .B      (b_sl),
        .s      (s_q),
        .m      (m_q),
        .cy_in  (cy_q),
        .F      (f_sl),
        .cy_out (cy_sl)
`ifdef ULA_OVF_EN
        ,
        .cy_msb (cy_msb_sl)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= OCIOSO;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            m_q         <= MODO_ARIT;
            cy_q        <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            c_out_q     <= 1'b0;
            aeqb_q      <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ULA_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        s_q        <= s;
                        m_q        <= m;
                        cy_q       <= (m == MODO_ARIT) & c_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        estado_q   <= CALC;
                    end
                end
                CALC: begin
                    res_q <= res_d;
                    cy_q  <= cy_sl;
                    if (cnt_q == ULTIMA) begin
                        c_out_q     <= cy_sl;
                        aeqb_q      <= (a_q == b_q);
                        zero_q      <= (res_d == '0);
`ifdef ULA_OVF_EN
                        ovf_q       <= cy_msb_sl ^ cy_sl;
`endif
                        out_valid_q <= 1'b1;
                        estado_q    <= PRONTO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRONTO: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        estado_q    <= OCIOSO;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f         = res_q;
    assign c_out     = c_out_q;
    assign a_eq_b    = aeqb_q;
    assign zero      = zero_q;
`ifdef ULA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ula_serial_nbit.sv
// Self-checking bench for ula_serial_nbit (WIDTH=8), scoreboard based.
// Covers reset, arithmetic, logic, flags, backpressure, abort, back-to-back.
module tb_ula_serial_nbit;

    localparam int W  = 8;
    localparam int NF = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   s = '0;
    logic         m = 1'b0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] f;
    logic         c_out;
    logic         a_eq_b;
    logic         zero;
`ifdef ULA_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    ula_serial_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .c_out     (c_out),
        .a_eq_b    (a_eq_b),
        .zero      (zero)
`ifdef ULA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [W-1:0] f;
        logic         co;
        logic         aeq;
        logic         zr;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [W-1:0] ef, input logic eco,
                                input logic eaeq, input logic ezr,
                                input logic eov);
        exp_t e;
        e.f   = ef;
        e.co  = eco;
        e.aeq = eaeq;
        e.zr  = ezr;
        e.ov  = eov;
        return e;
    endfunction

    // Full-width reference: one wide add instead of a 4-bit ripple.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [3:0] sel, input logic md,
                                   input logic ci);
        logic [W-1:0] p, g, lo;
        logic [W:0]   sum;
        exp_t         e;
        p = x | (y & {W{sel[0]}}) | (~y & {W{sel[1]}});
        g = (x & y & {W{sel[3]}}) | (x & ~y & {W{sel[2]}});
        if (!md) begin
            sum  = {1'b0, p} + {1'b0, g} + {{W{1'b0}}, ci};
            lo   = {1'b0, p[W-2:0]} + {1'b0, g[W-2:0]} + {{(W-1){1'b0}}, ci};
            e.f  = sum[W-1:0];
            e.co = sum[W];
            e.ov = lo[W-1] ^ sum[W];
        end else begin
            e.f  = ~(p ^ g);
            e.co = 1'b0;
            e.ov = 1'b0;
        end
        e.aeq = (x == y);
        e.zr  = (e.f == '0);
        return e;
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [3:0] sel, input logic md, input logic ci,
                        input bit push, input exp_t e);
        int n = 0;
        @(negedge clk);
        a = x; b = y; s = sel; m = md; c_in = ci;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready got %b want 1", in_ready);
        end
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        s = 4'($urandom); m = 1'($urandom); c_in = 1'($urandom);
    endtask

    task automatic drain(input string name);
        int   n = 0;
        exp_t e;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s out_valid timeout got %b want 1", name, out_valid);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected result f=%h", name, f);
            @(posedge clk); #1;
        end else begin
            e = sb.pop_front();
            if (f !== e.f) begin
                errors++; $display("FAIL %s f got %h want %h", name, f, e.f);
            end
            checks++;
            if (c_out !== e.co) begin
                errors++; $display("FAIL %s c_out got %b want %b", name, c_out, e.co);
            end
            checks++;
            if (a_eq_b !== e.aeq) begin
                errors++; $display("FAIL %s a_eq_b got %b want %b", name, a_eq_b, e.aeq);
            end
            checks++;
            if (zero !== e.zr) begin
                errors++; $display("FAIL %s zero got %b want %b", name, zero, e.zr);
            end
`ifdef ULA_OVF_EN
            checks++;
            if (ovf !== e.ov) begin
                errors++; $display("FAIL %s ovf got %b want %b", name, ovf, e.ov);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs in_ready/out_valid got %b%b want 10", in_ready, out_valid);
        end
        checks++;
        if (f !== '0 || c_out !== 1'b0 || a_eq_b !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_out f,c,eq,z got %h %b %b %b want 00 0 0 0", f, c_out, a_eq_b, zero);
        end
`ifdef ULA_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ovf got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_arith();
        int lat = 0;
        out_ready = 1'b1;
        send(8'hF0, 8'h10, 4'b1001, 1'b0, 1'b0, 1, mk(8'h00, 1, 0, 1, 0));
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != NF + 1) begin
            errors++; $display("FAIL latency got %0d want %0d", lat, NF + 1);
        end
        drain("add_F0_10");
        send(8'h35, 8'h12, 4'b0110, 1'b0, 1'b1, 1, mk(8'h23, 1, 0, 0, 0));
        drain("sub_35_12");
        send(8'h12, 8'h35, 4'b0110, 1'b0, 1'b1, 1, mk(8'hDD, 0, 0, 0, 0));
        drain("sub_12_35");
    endtask

    task automatic test_logic();
        send(8'hAA, 8'hFF, 4'b0110, 1'b1, 1'b1, 1, mk(8'h55, 0, 0, 0, 0));
        drain("xor_AA_FF");
        send(8'hAA, 8'hFF, 4'b0000, 1'b1, 1'b1, 1, mk(8'h55, 0, 0, 0, 0));
        drain("not_AA");
        send(8'hAA, 8'hFF, 4'b1011, 1'b1, 1'b0, 1, mk(8'hAA, 0, 0, 0, 0));
        drain("and_AA_FF");
    endtask

    task automatic test_flags();
        send(8'h5A, 8'h5A, 4'b0110, 1'b0, 1'b1, 1, mk(8'h00, 1, 1, 1, 0));
        drain("eq_5A");
`ifdef ULA_OVF_EN
        send(8'h7F, 8'h01, 4'b1001, 1'b0, 1'b0, 1, mk(8'h80, 0, 0, 0, 1));
        drain("ovf_7F_01");
`endif
    endtask

    task automatic test_backpressure();
        exp_t e1, e2, es;
        int   n = 0;
        logic [W-1:0] x2, y2;
        e1 = model(8'hC3, 8'h4D, 4'b1001, 1'b0, 1'b1);
        x2 = 8'h0F; y2 = 8'h0F;
        e2 = model(x2, y2, 4'b0110, 1'b0, 1'b1);
        out_ready = 1'b0;
        send(8'hC3, 8'h4D, 4'b1001, 1'b0, 1'b1, 1, e1);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        es = sb.pop_front();
        a = x2; b = y2; s = 4'b0110; m = 1'b0; c_in = 1'b1;
        in_valid = 1'b1;
        sb.push_back(e2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || f !== es.f ||
                c_out !== es.co || zero !== es.zr || a_eq_b !== es.aeq) begin
                errors++;
                $display("FAIL bp_hold v/r/f/c got %b %b %h %b want 1 0 %h %b",
                         out_valid, in_ready, f, c_out, es.f, es.co);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release in_ready/out_valid got %b%b want 10", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept in_ready got %b want 0", in_ready);
        end
        drain("bp_new");
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        send(8'h77, 8'h22, 4'b1001, 1'b0, 1'b0, 0, mk('0, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== '0) begin
            errors++;
            $display("FAIL abort_state in_ready/out_valid/f got %b %b %h want 1 0 00",
                     in_ready, out_valid, f);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_result out_valid seen got %b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        realtime t0;
        int      cyc;
        out_ready = 1'b1;
        t0 = $realtime;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    logic [W-1:0] x, y;
                    logic [3:0]   sel;
                    logic         md, ci;
                    x = W'($urandom); y = (i % 4 == 0) ? x : W'($urandom);
                    sel = 4'($urandom); md = 1'($urandom); ci = 1'($urandom);
                    send(x, y, sel, md, ci, 1, model(x, y, sel, md, ci));
                end
            end
            begin
                for (int j = 0; j < 12; j++) drain("b2b");
            end
        join
        cyc = int'(($realtime - t0) / 10.0);
        checks++;
        if (cyc > 12 * (NF + 2) + 4) begin
            errors++;
            $display("FAIL b2b_throughput cycles got %0d want <= %0d", cyc, 12 * (NF + 2) + 4);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_flags();
        test_backpressure();
        test_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_serial_nbit.md
Name: ula_serial_nbit

Overview:
- Parametrised successor of the team's 4-bit 74181-style ALU: WIDTH-bit operands, same 16-function select `s` and mode `m`.
- Computes serially, one 4-bit slice per clock, LSB slice first, with the carry rippled through a register between slices.
- Operand and result transfers use valid/ready handshakes.
- Sits between operand registers and result writeback where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- NUM_FATIAS, WIDTH/4, derived slice count; localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- s  in  4  function select
- m  in  1  mode: 0 arithmetic, 1 logic
- c_in  in  1  active-high carry into the LSB slice (arithmetic only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- f  out  WIDTH  result
- c_out  out  1  carry out of the MSB slice; 0 in logic mode
- a_eq_b  out  1  1 when captured a == captured b, for every s and m
- zero  out  1  1 when f == 0

Behaviour:
- Reset: state OCIOSO, in_ready=1, out_valid=0, f=0, c_out=0, a_eq_b=0, zero=0, slice counter=0, carry register=0.
- Per-slice function, with A, B being the current 4-bit slices:
  - P = A | (B & {4{s[0]}}) | (~B & {4{s[1]}})
  - G = (A & B & {4{s[3]}}) | (A & ~B & {4{s[2]}})
  - Arithmetic (m=0): {cy_out, F} = P + G + cy_in, 5-bit sum. The slice carry is real for all 16 selects, with no forced zeros.
  - Logic (m=1): F = ~(P ^ G); cy_out = 0.
  - Examples: s=1001 gives A+B+c; s=0110 gives A+~B+c (A-B when c_in=1); s=0000 logic gives ~A; s=0110 logic gives A^B.
- FSM:
  - OCIOSO: in_ready=1. On in_valid: capture a, b, s, m, c_in, carry register <= c_in (0 when m=1), counter <= 0, go to CALC.
  - CALC: in_ready=0. Each cycle compute slice[counter] and write its F into result bits [4*counter+3 : 4*counter]; carry register <= cy_out. After slice NUM_FATIAS-1: c_out <= its cy_out, flags updated, go to PRONTO.
  - PRONTO: out_valid=1; f, c_out, a_eq_b, zero held stable. On out_ready: go to OCIOSO.
- Latency: accept edge + NUM_FATIAS CALC cycles; out_valid rises on the cycle after the last slice.
- Throughput: one operation per NUM_FATIAS+2 cycles minimum. No overlap: in_ready is 0 in CALC and PRONTO.
- Inputs a/b/s/m/c_in may change freely after acceptance; only captured copies are used.
- Holding out_ready=0 indefinitely in PRONTO keeps the result stable and blocks new operands.
- rst asserted in CALC or PRONTO aborts the operation: all registers return to reset values on the next edge and the result is discarded.
- WIDTH=4: a single CALC cycle, bit-equivalent to the per-slice equations above.

Optional Feature:
- Macro: ULA_OVF_EN.
- Defined: adds output port `ovf` (1 bit), registered with the other flags.
  - ovf = carry into the MSB bit XOR c_out, for m=0.
  - ovf = 0 for m=1.
  - Reset value 0.
- Undefined: no `ovf` port and no MSB-carry logic.

Decomposition:
- Package ula_pkg:
  - typedef enum logic[1:0] {OCIOSO, CALC, PRONTO} estado_t
  - typedef logic[3:0] sel_t
  - constants MODO_ARIT=1'b0, MODO_LOG=1'b1
- Sub-module ula_fatia4: combinational 4-bit slice.
  - Inputs: A, B, s, m, cy_in.
  - Outputs: F, cy_out, cy_msb (carry into bit 3, for ovf).
  - Instantiated once and time-multiplexed across slices.

Test Plan:
- WIDTH=8, a=F0, b=10, s=1001, m=0, c_in=0 -> after 2 CALC cycles out_valid=1, f=00, c_out=1, zero=1, a_eq_b=0.
- a=35, b=12, s=0110, m=0, c_in=1 -> f=23, c_out=1. Then a=12, b=35 -> f=DD, c_out=0 (borrow).
- a=AA, b=FF, s=0110, m=1 -> f=55, c_out=0. Repeat with s=0000 -> f=55; with s=1011 -> f=AA.
- a=b=5A, s=0110, m=0, c_in=1 -> f=00, a_eq_b=1, zero=1, c_out=1. With ULA_OVF_EN: a=7F, b=01, s=1001, c_in=0 -> f=80, ovf=1, c_out=0.
- Backpressure: out_ready=0 for 5 cycles in PRONTO -> f/flags stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> OCIOSO next cycle, new operand accepted.
- rst pulsed on the first CALC cycle -> next cycle state OCIOSO, out_valid=0, f=00, no result ever presented.
